// File: rtl/chunked_add_pkg.sv
// rtl/chunked_add_pkg.sv - shared state encoding and default sizes for the chunked adder
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/chunk_ripple_adder.sv
// rtl/chunk_ripple_adder.sv - CHUNK-bit ripple of full-adder cells
module chunk_ripple_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  // carry into the top bit, needed for signed overflow on the last chunk
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_add_sub.sv
// rtl/chunked_add_sub.sv - multi-cycle add/subtract, one CHUNK-bit slice per cycle, LSB first
module chunked_add_sub
  import chunked_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] c_sum;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] sum_next;

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_adder (
    .a     (a_sh[CHUNK-1:0]),
    .b     (b_sh[CHUNK-1:0]),
    .cin   (carry),
    .sum   (c_sum),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  // Result fills from the top; after NCHUNK shifts chunk 0 sits at the LSB.
  always_comb begin
    sum_next                   = sum >> CHUNK;
    sum_next[WIDTH-1 -: CHUNK] = c_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // subtract is a + ~b + ~cin, so fold the inversions in at capture
            a_sh     <= a;
            b_sh     <= sub ? ~b : b;
            carry    <= sub ? ~cin : cin;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> CHUNK;
          b_sh  <= b_sh >> CHUNK;
          carry <= c_out;
          sum   <= sum_next;
          k     <= k + 1'b1;
          if (k == LAST_K) begin
            cout      <= c_out;
            ovf       <= c_msb ^ c_out;
            zero      <= (sum_next == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_sub.sv
// tb/tb_chunked_add_sub.sv - randomized check of chunked_add_sub against an arithmetic model
module tb_chunked_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready, in_valid1, out_ready1, cin, sub;
  logic [31:0] a, b;
  logic        rdy16, vld16, co16, ov16, z16;
  logic [15:0] s16;
  logic        rdy32, vld32, co32, ov32, z32;
  logic [31:0] s32;
  logic        rdy8, vld8, co8, ov8, z8;
  logic [7:0]  s8;

  int n_cmp = 0;
  int n_bad = 0;

  chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(vld16), .out_ready(out_ready), .sum(s16),
    .cout(co16), .ovf(ov16), .zero(z16));

  chunked_add_sub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(vld32), .out_ready(out_ready), .sum(s32),
    .cout(co32), .ovf(ov32), .zero(z32));

  chunked_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(rdy8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
    .out_valid(vld8), .out_ready(out_ready1), .sum(s8),
    .cout(co8), .ovf(ov8), .zero(z8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic on the operands; flags from signs and magnitude.
  task automatic model(input int w, input longint unsigned ma, input longint unsigned mb,
                       input bit mc, input bit ms, output longint unsigned rs,
                       output bit rco, output bit rov, output bit rz);
    longint unsigned mask, full;
    bit sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    ma   = ma & mask;
    mb   = mb & mask;
    if (!ms) begin
      full = ma + mb + 64'(mc);
      rco  = full[w];
    end else begin
      full = ma - mb - 64'(mc);
      rco  = (ma >= mb + 64'(mc));
    end
    rs  = full & mask;
    sa  = ma[w-1];
    sb  = mb[w-1];
    sr  = rs[w-1];
    rov = ms ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    rz  = (rs == 0);
  endtask

  task automatic check_result(input string tag, input int w, input logic [31:0] ta,
                              input logic [31:0] tb_, input bit tc, input bit ts,
                              input logic [63:0] gs, input logic gco, input logic gov,
                              input logic gz);
    longint unsigned es;
    bit eco, eov, ez;
    model(w, 64'(ta), 64'(tb_), tc, ts, es, eco, eov, ez);
    check({tag, ".sum"}, gs, es);
    check({tag, ".cout"}, 64'(gco), 64'(eco));
    check({tag, ".ovf"}, 64'(gov), 64'(eov));
    check({tag, ".zero"}, 64'(gz), 64'(ez));
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input bit tc,
                        input bit ts, input int hold,
                        output logic [15:0] r16, output logic [31:0] r32,
                        output logic [2:0] f16, output logic [2:0] f32);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready16", 64'(rdy16), 64'd1);
    check("in_ready32", 64'(rdy32), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (vld16) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    check("valid32", 64'(vld32), 64'd1);
    check_result("w16", 16, ta, tb_, tc, ts, 64'(s16), co16, ov16, z16);
    check_result("w32", 32, ta, tb_, tc, ts, 64'(s32), co32, ov32, z32);
    r16 = s16; r32 = s32;
    f16 = {co16, ov16, z16};
    f32 = {co32, ov32, z32};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold.valid", 64'(vld16), 64'd1);
      check("hold.in_ready", 64'(rdy16), 64'd0);
      check("hold.sum16", 64'({s16, co16, ov16, z16}), 64'({r16, f16}));
      check("hold.sum32", 64'({s32, co32, ov32, z32}), 64'({r32, f32}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post.valid16", 64'(vld16), 64'd0);
    check("post.in_ready16", 64'(rdy16), 64'd1);
    check("post.valid32", 64'(vld32), 64'd0);
  endtask

  task automatic run_op8(input logic [31:0] ta, input logic [31:0] tb_, input bit tc,
                         input bit ts);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (vld8) break;
      @(posedge clk);
      lat++;
    end
    check("latency8", 64'(lat), 64'd1);
    check_result("w8", 8, ta, tb_, tc, ts, 64'(s8), co8, ov8, z8);
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
    check("post.valid8", 64'(vld8), 64'd0);
    check("post.in_ready8", 64'(rdy8), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r16;
    logic [31:0] r32;
    logic [2:0]  f16, f32;
    bit          seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.in_ready16", 64'(rdy16), 64'd1);
    check("rst.out_valid16", 64'(vld16), 64'd0);
    check("rst.outs16", 64'({s16, co16, ov16, z16}), 64'd0);
    check("rst.in_ready32", 64'(rdy32), 64'd1);
    check("rst.in_ready8", 64'(rdy8), 64'd1);
    rst_n = 1'b1;

    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r16, r32, f16, f32);
    check("d36.sum", 64'(r16), 64'h0000);
    check("d36.flags", 64'(f16), 64'(3'b101));
    run_op(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 0, r16, r32, f16, f32);
    check("d37.sum", 64'(r16), 64'h8000);
    check("d37.flags", 64'(f16), 64'(3'b010));
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, r16, r32, f16, f32);
    check("d38a.sum", 64'(r16), 64'hFFFE);
    check("d38a.flags", 64'(f16), 64'(3'b000));
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, r16, r32, f16, f32);
    check("d38b.sum", 64'(r16), 64'hFFFD);
    run_op(32'h0000_ABCD, 32'h0000_1111, 1'b0, 1'b0, 3, r16, r32, f16, f32);
    check("d39.sum", 64'(r16), 64'hBCDE);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, r16, r32, f16, f32);
    check("d41.sum", 64'(r32), 64'h7FFF_FFFF);
    check("d41.cout_ovf", 64'(f32[2:1]), 64'(2'b11));

    // abort mid-operation with an asynchronous reset pulse
    @(negedge clk);
    a = 32'h1111; b = 32'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.in_ready", 64'(rdy16), 64'd1);
    check("abort.out_valid", 64'(vld16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | vld16 | vld32;
    end
    check("abort.no_valid", 64'(seen), 64'd0);
    run_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 0, r16, r32, f16, f32);
    check("d40.sum", 64'(r16), 64'h5555);

    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
             r16, r32, f16, f32);
    end

    run_op8(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    run_op8(32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run_op8($urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
